// File: rtl/const_time_out_stage.sv
// Constant-time output stage: buffers core results, emits one slot every PERIOD cycles.
// Latency: 1..PERIOD cycles from push (empty FIFO, RUN) to registered output.
// Backpressure: o_in_ready = !full from registered pointers; pushes while full are dropped and counted.
//
// Ports (const_time_out_stage):
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_en, i_flush       start/continue emission, drain-then-stop request
//   i_in_valid/_data    result from the core
//   o_in_ready          FIFO not full
//   o_out_valid/_data   one-cycle pulse per emission slot, emitted value
//   o_out_filler        slot carried no real result
//   o_drop_cnt          saturating count of results lost while full
//   o_busy              state machine not idle

// ---------------------------------------------------------------------------
// Result FIFO: pointer-pair ring buffer with one extra wrap bit per pointer.
// Latency: head visible combinationally; push written on the clock edge.
// Backpressure: caller decides push/pop; full/empty come from registered pointers.
// ---------------------------------------------------------------------------
module const_time_out_stage_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage carries no reset: entries are only read after being written.
    // When full with a simultaneous pop, the write lands on the slot being
    // read; the head is sampled before the edge so the old value is emitted.
    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];
endmodule

// ---------------------------------------------------------------------------
// Constant-time output stage top.
// Latency: 1..PERIOD cycles (next slot plus one register stage).
// Backpressure: none toward the sink; toward the core via o_in_ready/drops.
// ---------------------------------------------------------------------------
module const_time_out_stage #(
    parameter int WIDTH  = 64,
    parameter int DEPTH  = 4,
    parameter int PERIOD = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_flush,
    input  logic             i_in_valid,
    input  logic [WIDTH-1:0] i_in_data,
    output logic             o_in_ready,
    output logic             o_out_valid,
    output logic [WIDTH-1:0] o_out_data,
    output logic             o_out_filler,
    output logic [7:0]       o_drop_cnt,
    output logic             o_busy
);
    localparam int             CW        = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0]  LAST_SLOT = CW'(PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_slot_cnt;

    logic             w_full;
    logic             w_empty;
    logic [WIDTH-1:0] w_head;
    logic             w_push;
    logic             w_pop;
    logic             w_drop;

    logic             w_slot;
    logic             w_emit_vld;
    logic             w_emit_filler;
    logic [WIDTH-1:0] w_emit_data;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_filler;
    logic [7:0]       r_drop_cnt;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // ---------------- FSM: next-state logic ----------------
    // Flush is checked before en so a simultaneous en=0/flush=1 drains.
    // Leaving RUN on en=0 waits for a slot so the cadence is never cut short.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (i_en) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (i_flush)             w_state_nxt = ST_FLUSH;
                else if (!i_en && w_slot) w_state_nxt = ST_IDLE;
            end
            ST_FLUSH: begin
                if (w_slot && w_empty) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- FSM: output logic ----------------
    // Slot timing depends only on state and the free-running counter, never
    // on FIFO occupancy or input data.
    always_comb begin
        w_slot        = 1'b0;
        w_pop         = 1'b0;
        w_emit_vld    = 1'b0;
        w_emit_filler = 1'b0;
        w_emit_data   = '0;
        if ((r_state == ST_RUN || r_state == ST_FLUSH) && r_slot_cnt == LAST_SLOT) begin
            w_slot = 1'b1;
        end
        if (w_slot) begin
            if (!w_empty) begin
                w_pop       = 1'b1;
                w_emit_vld  = 1'b1;
                w_emit_data = w_head;
            end else if (r_state == ST_RUN) begin
                // Empty slot in RUN still pulses so timing leaks nothing.
                w_emit_vld    = 1'b1;
                w_emit_filler = 1'b1;
            end
        end
    end

    // Push is allowed while full when the same cycle pops, since the pop
    // frees the entry the write lands on.
    assign w_push = i_in_valid && (!w_full || w_pop);
    assign w_drop = i_in_valid && w_full && !w_pop;

    // ---------------- Slot counter ----------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_slot_cnt <= '0;
        end else if (r_state == ST_IDLE) begin
            r_slot_cnt <= '0;
        end else if (r_slot_cnt == LAST_SLOT) begin
            r_slot_cnt <= '0;
        end else begin
            r_slot_cnt <= r_slot_cnt + 1'b1;
        end
    end

    // ---------------- Registered outputs ----------------
    // out_data holds its last value between slots and on the empty FLUSH slot.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_filler <= 1'b0;
        end else begin
            r_out_valid  <= w_emit_vld;
            r_out_filler <= w_emit_filler;
            if (w_emit_vld) r_out_data <= w_emit_data;
        end
    end

    // ---------------- Drop counter (saturating) ----------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop && r_drop_cnt != 8'hFF) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    // ---------------- Result FIFO ----------------
    const_time_out_stage_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (i_in_data),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign o_in_ready   = !w_full;
    assign o_out_valid  = r_out_valid;
    assign o_out_data   = r_out_data;
    assign o_out_filler = r_out_filler;
    assign o_drop_cnt   = r_drop_cnt;
    assign o_busy       = (r_state != ST_IDLE);
endmodule

// File: tb/tb_const_time_out_stage.sv
// Testbench for const_time_out_stage: scenario tasks against a queue-based reference model.
// Latency: model predicts outputs visible 1 time unit after each rising edge.
// Backpressure: model accepts pushes while below DEPTH or when the same edge pops.
module tb_const_time_out_stage;
    localparam int W = 64;
    localparam int D = 4;
    localparam int P = 4;

    logic         clk;
    logic         rst;
    logic         en;
    logic         flush;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_filler;
    logic [7:0]   drop_cnt;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    const_time_out_stage #(.WIDTH(W), .DEPTH(D), .PERIOD(P)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_en         (en),
        .i_flush      (flush),
        .i_in_valid   (in_valid),
        .i_in_data    (in_data),
        .o_in_ready   (in_ready),
        .o_out_valid  (out_valid),
        .o_out_data   (out_data),
        .o_out_filler (out_filler),
        .o_drop_cnt   (drop_cnt),
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- Reference model ----------------
    // Mode: 0 idle, 1 run, 2 flush. Slots fire at edges start+k*P (k>=1),
    // where start is the edge at which RUN was entered.
    int           edge_n  = 0;
    int           m_mode  = 0;
    int           m_start = 0;
    int           m_drop  = 0;
    logic [W-1:0] mq[$];
    logic         exp_valid  = 1'b0;
    logic [W-1:0] exp_data   = '0;
    logic         exp_filler = 1'b0;
    logic         exp_rdy    = 1'b1;
    logic         exp_busy   = 1'b0;
    logic [7:0]   exp_drop   = '0;

    task automatic model_reset();
        mq.delete();
        m_mode = 0; m_drop = 0;
        exp_valid = 1'b0; exp_data = '0; exp_filler = 1'b0;
        exp_rdy = 1'b1; exp_busy = 1'b0; exp_drop = '0;
    endtask

    task automatic model_eval(input logic e, input logic f, input logic v, input logic [W-1:0] d);
        bit slot;
        bit popped;
        int sz;
        slot   = (m_mode != 0) && (edge_n > m_start) && (((edge_n - m_start) % P) == 0);
        sz     = mq.size();
        popped = 0;
        exp_valid  = 1'b0;
        exp_filler = 1'b0;
        if (slot) begin
            if (sz > 0) begin
                exp_valid = 1'b1; exp_data = mq.pop_front(); popped = 1;
            end else if (m_mode == 1) begin
                exp_valid = 1'b1; exp_data = '0; exp_filler = 1'b1;
            end
        end
        if (v) begin
            if (sz < D || popped) mq.push_back(d);
            else if (m_drop < 255) m_drop++;
        end
        case (m_mode)
            0: if (e) begin m_mode = 1; m_start = edge_n; end
            1: if (f) m_mode = 2; else if (!e && slot) m_mode = 0;
            default: if (slot && sz == 0) m_mode = 0;
        endcase
        exp_rdy  = (mq.size() < D);
        exp_busy = (m_mode != 0);
        exp_drop = 8'(m_drop);
    endtask

    // One clock of stimulus; afterwards the model holds the expected outputs.
    task automatic step(input logic e, input logic f, input logic v, input logic [W-1:0] d);
        en = e; flush = f; in_valid = v; in_data = d;
        @(posedge clk);
        edge_n++;
        model_eval(e, f, v, d);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        #1;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [W-1:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // ---------------- Scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; en = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        #2;
        checks++; if (out_valid !== 1'b0)  begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== '0)     begin failures++; $display("FAIL reset_data got=%0h exp=0", out_data); end
        checks++; if (out_filler !== 1'b0) begin failures++; $display("FAIL reset_filler got=%b exp=0", out_filler); end
        checks++; if (drop_cnt !== 8'd0)   begin failures++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt); end
        checks++; if (in_ready !== 1'b1)   begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
        checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        do_reset();
    endtask

    task automatic test_filler_cadence();
        int pulses = 0;
        do_reset();
        step(1'b1, 1'b0, 1'b0, '0);
        for (int k = 1; k <= 20; k++) begin
            step(1'b1, 1'b0, 1'b0, '0);
            checks++;
            if (out_valid !== ((k % P) == 0)) begin
                failures++; $display("FAIL cadence_valid k=%0d got=%b exp=%b", k, out_valid, (k % P) == 0);
            end
            if (out_valid === 1'b1) begin
                pulses++;
                checks++;
                if (out_filler !== 1'b1 || out_data !== '0) begin
                    failures++; $display("FAIL cadence_filler k=%0d got filler=%b data=%0h exp filler=1 data=0", k, out_filler, out_data);
                end
            end
        end
        checks++; if (pulses != 5) begin failures++; $display("FAIL cadence_pulses got=%0d exp=5", pulses); end
    endtask

    task automatic test_push_order();
        logic [W-1:0] a = rnd64();
        logic [W-1:0] b = rnd64();
        logic [W-1:0] got[$];
        int last_pulse = -1;
        int pa = 0;
        int ea = -1;
        for (int i = 0; i < int'($urandom_range(0, 3)); i++) step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b1, a);
        pa = edge_n;
        if (out_valid === 1'b1) last_pulse = edge_n;
        step(1'b1, 1'b0, 1'b1, b);
        for (int i = 0; i < 13; i++) begin
            if (i > 0) step(1'b1, 1'b0, 1'b0, '0);
            checks++;
            if (out_valid !== exp_valid || out_data !== exp_data || out_filler !== exp_filler) begin
                failures++; $display("FAIL order_model edge=%0d got v=%b d=%0h f=%b exp v=%b d=%0h f=%b",
                                     edge_n, out_valid, out_data, out_filler, exp_valid, exp_data, exp_filler);
            end
            if (out_valid === 1'b1) begin
                if (last_pulse >= 0) begin
                    checks++;
                    if (edge_n - last_pulse != P) begin
                        failures++; $display("FAIL order_spacing got=%0d exp=%0d", edge_n - last_pulse, P);
                    end
                end
                last_pulse = edge_n;
                if (out_filler === 1'b0) begin
                    got.push_back(out_data);
                    if (ea < 0) ea = edge_n;
                end
            end
        end
        checks++;
        if (got.size() != 2 || got[0] !== a || got[1] !== b) begin
            failures++; $display("FAIL order_values got_n=%0d exp_n=2 first=%0h exp=%0h", got.size(), (got.size() > 0) ? got[0] : '0, a);
        end
        checks++;
        if (ea - pa < 1 || ea - pa > P) begin
            failures++; $display("FAIL order_latency got=%0d exp=1..%0d", ea - pa, P);
        end
    endtask

    task automatic test_full_idle();
        logic [W-1:0] vals[6];
        logic [W-1:0] got[$];
        do_reset();
        for (int i = 0; i < 6; i++) begin
            vals[i] = rnd64();
            step(1'b0, 1'b0, 1'b1, vals[i]);
            checks++;
            if (in_ready !== (i + 1 < D)) begin
                failures++; $display("FAIL idle_ready n=%0d got=%b exp=%b", i + 1, in_ready, (i + 1 < D));
            end
        end
        checks++; if (drop_cnt !== 8'd2) begin failures++; $display("FAIL idle_drop got=%0d exp=2", drop_cnt); end
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL idle_quiet got busy=%b v=%b exp 0 0", busy, out_valid); end
        for (int i = 0; i < 18; i++) begin
            step(1'b1, 1'b0, 1'b0, '0);
            checks++;
            if (out_valid !== exp_valid || out_data !== exp_data || in_ready !== exp_rdy) begin
                failures++; $display("FAIL idle_model edge=%0d got v=%b d=%0h r=%b exp v=%b d=%0h r=%b",
                                     edge_n, out_valid, out_data, in_ready, exp_valid, exp_data, exp_rdy);
            end
            if (out_valid === 1'b1 && out_filler === 1'b0) got.push_back(out_data);
        end
        checks++;
        if (got.size() != 4) begin
            failures++; $display("FAIL idle_count got=%0d exp=4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got[i] !== vals[i]) begin failures++; $display("FAIL idle_value i=%0d got=%0h exp=%0h", i, got[i], vals[i]); end
            end
        end
    endtask

    task automatic test_full_pop_push();
        logic [W-1:0] vals[5];
        logic [W-1:0] got[$];
        do_reset();
        for (int i = 0; i < 4; i++) begin vals[i] = rnd64(); step(1'b0, 1'b0, 1'b1, vals[i]); end
        vals[4] = rnd64();
        step(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < P - 1; i++) step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b1, vals[4]);
        checks++; if (drop_cnt !== 8'd0) begin failures++; $display("FAIL fullpp_drop got=%0d exp=0", drop_cnt); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fullpp_ready got=%b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b1 || out_data !== vals[0]) begin
            failures++; $display("FAIL fullpp_first got v=%b d=%0h exp v=1 d=%0h", out_valid, out_data, vals[0]);
        end
        for (int i = 0; i < 17; i++) begin
            step(1'b1, 1'b0, 1'b0, '0);
            if (out_valid === 1'b1 && out_filler === 1'b0) got.push_back(out_data);
        end
        checks++;
        if (got.size() != 4) begin
            failures++; $display("FAIL fullpp_count got=%0d exp=4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got[i] !== vals[i + 1]) begin failures++; $display("FAIL fullpp_value i=%0d got=%0h exp=%0h", i, got[i], vals[i + 1]); end
            end
        end
    endtask

    task automatic test_flush();
        logic [W-1:0] vals[3];
        int k = 0;
        do_reset();
        for (int i = 0; i < 3; i++) begin vals[i] = rnd64(); step(1'b0, 1'b0, 1'b1, vals[i]); end
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, '0);
        for (int rel = 2; rel < 20; rel++) begin
            step(1'b0, 1'b0, 1'b0, '0);
            checks++;
            if (out_valid !== (rel == 4 || rel == 8 || rel == 12) || out_filler !== 1'b0) begin
                failures++; $display("FAIL flush_valid rel=%0d got v=%b f=%b exp v=%b f=0", rel, out_valid, out_filler,
                                     (rel == 4 || rel == 8 || rel == 12));
            end
            if (out_valid === 1'b1 && k < 3) begin
                checks++;
                if (out_data !== vals[k]) begin failures++; $display("FAIL flush_data i=%0d got=%0h exp=%0h", k, out_data, vals[k]); end
                k++;
            end
            checks++;
            if (busy !== (rel < 16) || busy !== exp_busy) begin
                failures++; $display("FAIL flush_busy rel=%0d got=%b exp=%b", rel, busy, (rel < 16));
            end
        end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        step(1'b1, 1'b0, 1'b1, rnd64());
        step(1'b1, 1'b0, 1'b1, rnd64());
        for (int i = 0; i < P - 2; i++) step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b1, rnd64());
        checks++; if (out_valid !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL midrst_pre got v=%b busy=%b exp 1 1", out_valid, busy); end
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_filler !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || drop_cnt !== 8'd0) begin
            failures++; $display("FAIL midrst_async got v=%b d=%0h f=%b busy=%b r=%b drop=%0d exp all reset values",
                                 out_valid, out_data, out_filler, busy, in_ready, drop_cnt);
        end
        do_reset();
        step(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < P; i++) step(1'b1, 1'b0, 1'b0, '0);
        checks++;
        if (out_valid !== 1'b1 || out_filler !== 1'b1 || out_data !== '0) begin
            failures++; $display("FAIL midrst_first got v=%b f=%b d=%0h exp v=1 f=1 d=0", out_valid, out_filler, out_data);
        end
    endtask

    task automatic test_random();
        int dens = 1;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) dens = int'($urandom_range(0, 4));
            step(($urandom % 8) != 0, ($urandom % 30) == 0, ($urandom % 4) < dens, rnd64());
            checks++;
            if (out_valid !== exp_valid || out_data !== exp_data || out_filler !== exp_filler ||
                in_ready !== exp_rdy || busy !== exp_busy || drop_cnt !== exp_drop) begin
                failures++;
                $display("FAIL random edge=%0d got v=%b d=%0h f=%b r=%b b=%b drop=%0d exp v=%b d=%0h f=%b r=%b b=%b drop=%0d",
                         edge_n, out_valid, out_data, out_filler, in_ready, busy, drop_cnt,
                         exp_valid, exp_data, exp_filler, exp_rdy, exp_busy, exp_drop);
            end
        end
    endtask

    initial begin
        test_reset();
        test_filler_cadence();
        test_push_order();
        test_full_idle();
        test_full_pop_push();
        test_flush();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
